// File: rtl/hazard_control.sv
// Load-use / redirect / hlt control for the fetch-execute pipeline: drives PC and
// pipeline-register stall, flush and bubble controls, and counts stall/flush events.
module hazard_control #(
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_read_reg1,
  input  logic [4:0]       id_read_reg2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_hlt,
  input  logic [4:0]       ex_write_reg,
  input  logic             ex_reg_write,
  input  logic             ex_mem_reg,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic             fd_flush,
  output logic             fe_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int REM_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [REM_W-1:0] REM_RELOAD = REM_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_e;

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // x0 is never a real producer, so a load targeting it cannot cause a hazard
  assign hz = ex_mem_reg & ex_reg_write & (ex_write_reg != 5'd0) &
              ((id_uses_rs1 & (id_read_reg1 == ex_write_reg)) |
               (id_uses_rs2 & (id_read_reg2 == ex_write_reg)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ex_redirect) begin
          flush_cnt_d = sat_inc(flush_cnt_q);
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            rem_d   = REM_RELOAD;
          end
        end else if (hz) begin
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (id_hlt) begin
          state_d = ST_HALT;
        end
      end
      ST_FLUSH: begin
        if (ex_redirect) begin
          flush_cnt_d = sat_inc(flush_cnt_q);
          rem_d       = REM_RELOAD;
        end else begin
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) state_d = ST_RUN;
        end
      end
      ST_HALT: ;
      default: state_d = ST_RUN;
    endcase
  end

  // Mealy controls: same-cycle response, held low while reset is asserted
  always_comb begin
    pc_stall  = 1'b0;
    fd_stall  = 1'b0;
    fd_flush  = 1'b0;
    fe_bubble = 1'b0;
    halted    = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_RUN: begin
          if (ex_redirect) begin
            fd_flush  = 1'b1;
            fe_bubble = 1'b1;
          end else if (hz) begin
            pc_stall  = 1'b1;
            fd_stall  = 1'b1;
            fe_bubble = 1'b1;
          end else if (id_hlt) begin
            pc_stall  = 1'b1;
            fd_stall  = 1'b1;
            fe_bubble = 1'b1;
            halted    = 1'b1;
          end
        end
        ST_FLUSH: begin
          fd_flush  = 1'b1;
          fe_bubble = 1'b1;
        end
        ST_HALT: begin
          pc_stall  = 1'b1;
          fd_stall  = 1'b1;
          fe_bubble = 1'b1;
          halted    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control (CNT_W=4, FLUSH_CYCLES=2).
module tb_hazard_control;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_read_reg1, id_read_reg2, ex_write_reg;
  logic             id_uses_rs1, id_uses_rs2, id_hlt;
  logic             ex_reg_write, ex_mem_reg, ex_redirect;
  logic             pc_stall, fd_stall, fd_flush, fe_bubble, halted;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [4:0]       ctl;

  int n_checks = 0;
  int n_errors = 0;

  // ctl = {pc_stall, fd_stall, fd_flush, fe_bubble, halted}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11010;
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_HALT  = 5'b11011;

  hazard_control #(.CNT_W(CNT_W), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_hlt(id_hlt),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_reg(ex_mem_reg), .ex_redirect(ex_redirect),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush),
    .fe_bubble(fe_bubble), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;
  assign ctl = {pc_stall, fd_stall, fd_flush, fe_bubble, halted};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_read_reg1 = '0; id_read_reg2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_hlt = 1'b0; ex_write_reg = '0; ex_reg_write = 1'b0; ex_mem_reg = 1'b0;
    ex_redirect = 1'b0;
  endtask

  task automatic set_hz(input logic [4:0] wr, input logic [4:0] r1, input logic u1);
    ex_mem_reg = 1'b1; ex_reg_write = 1'b1; ex_write_reg = wr;
    id_read_reg1 = r1; id_uses_rs1 = u1;
  endtask

  // advance one clock and settle just after the edge; inputs change here
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    clr();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ctl", ctl, C_NONE);
    chk("rst_stall_cnt", stall_count, 0);
    chk("rst_flush_cnt", flush_count, 0);
    #9 rst_n = 1'b1;
    cyc();

    // load-use on rs1
    set_hz(5'd5, 5'd5, 1'b1); #2;
    chk("ld_use_ctl", ctl, C_STALL);
    cyc(); clr(); #2;
    chk("ld_use_cnt", stall_count, 1);
    chk("ld_use_clear_ctl", ctl, C_NONE);
    // x0 producer and unused rs1 must not stall
    set_hz(5'd0, 5'd0, 1'b1); #2;
    chk("x0_ctl", ctl, C_NONE);
    cyc(); set_hz(5'd5, 5'd5, 1'b0); #2;
    chk("no_use_ctl", ctl, C_NONE);
    cyc(); clr(); #2;
    chk("no_stall_cnt", stall_count, 1);
    // load-use on rs2
    ex_mem_reg = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd9;
    id_read_reg2 = 5'd9; id_uses_rs2 = 1'b1; #2;
    chk("rs2_ctl", ctl, C_STALL);
    cyc(); clr(); #2;
    chk("rs2_cnt", stall_count, 2);

    // single redirect: two squash cycles
    ex_redirect = 1'b1; #2;
    chk("redir_c0", ctl, C_FLUSH);
    cyc(); ex_redirect = 1'b0; #2;
    chk("redir_c1", ctl, C_FLUSH);
    chk("redir_cnt", flush_count, 1);
    cyc(); #2;
    chk("redir_done", ctl, C_NONE);

    // redirect again, second pulse inside FLUSH restarts the squash
    ex_redirect = 1'b1; #2;
    cyc(); #2;
    chk("re_redir_c1", ctl, C_FLUSH);
    cyc(); ex_redirect = 1'b0; set_hz(5'd3, 5'd3, 1'b1); #2;
    chk("re_redir_c2", ctl, C_FLUSH);
    chk("re_redir_cnt", flush_count, 3);
    cyc(); clr(); #2;
    chk("re_redir_done", ctl, C_NONE);
    chk("flush_hz_ignored", stall_count, 2);

    // redirect beats hz and hlt
    ex_redirect = 1'b1; id_hlt = 1'b1; set_hz(5'd7, 5'd7, 1'b1); #2;
    chk("prio_ctl", ctl, C_FLUSH);
    cyc(); clr(); #2;
    chk("prio_flush_cnt", flush_count, 4);
    chk("prio_stall_cnt", stall_count, 2);
    chk("prio_c1", ctl, C_FLUSH);
    cyc(); #2;
    chk("prio_not_halted", ctl, C_NONE);

    // saturation: 20 hz cycles from 2
    set_hz(5'd4, 5'd4, 1'b1);
    for (int i = 0; i < 13; i++) cyc();
    #2;
    chk("sat_reach", stall_count, 15);
    for (int i = 0; i < 7; i++) cyc();
    #2;
    chk("sat_hold", stall_count, 15);
    chk("sat_ctl", ctl, C_STALL);
    cyc(); clr();

    // async reset mid-FLUSH
    ex_redirect = 1'b1;
    cyc(); ex_redirect = 1'b0; #2;
    chk("pre_rst_ctl", ctl, C_FLUSH);
    rst_n = 1'b0; #1;
    chk("async_rst_ctl", ctl, C_NONE);
    chk("async_rst_scnt", stall_count, 0);
    chk("async_rst_fcnt", flush_count, 0);
    #1 rst_n = 1'b1; #1;
    chk("post_rst_ctl", ctl, C_NONE);
    cyc();
    set_hz(5'd12, 5'd12, 1'b1); #2;
    chk("post_rst_stall", ctl, C_STALL);
    cyc(); clr(); #2;
    chk("post_rst_cnt", stall_count, 1);

    // hlt freezes everything until reset
    id_hlt = 1'b1; #2;
    chk("hlt_c0", ctl, C_HALT);
    cyc(); id_hlt = 1'b0; #2;
    chk("hlt_c1", ctl, C_HALT);
    ex_redirect = 1'b1; #2;
    chk("hlt_redir_ctl", ctl, C_HALT);
    cyc(); ex_redirect = 1'b0; set_hz(5'd6, 5'd6, 1'b1);
    cyc(); clr(); #2;
    chk("hlt_fcnt", flush_count, 0);
    chk("hlt_scnt", stall_count, 1);
    chk("hlt_ctl", ctl, C_HALT);
    rst_n = 1'b0; #1;
    chk("hlt_rst_ctl", ctl, C_NONE);
    chk("hlt_rst_scnt", stall_count, 0);
    #1 rst_n = 1'b1;
    cyc(); #2;
    chk("hlt_exit_ctl", ctl, C_NONE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
